led_pattern_sequencer: RTL and testbench

Sequencer for the board's 18-LED bar. It produces the pattern timebase from a programmable prescaler and drives a one-hot or bar pattern. Four modes are supported: bounce, rotate right, rotate left, and fill/drain. It replaces free-running per-clock LED shifting with a rate-controlled, run/step-controllable source, and sits between the top-level switches/keys and the LEDR outputs.

---
 rtl/led_seq_pkg.sv | 23 ++
 rtl/led_pattern_sequencer_if.sv | 26 ++
 rtl/led_tick_prescaler.sv | 35 +++
 rtl/led_pattern_sequencer.sv | 153 +++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and default sizes for the LED bar pattern sequencer.
package led_seq_pkg;

    localparam int unsigned N_LEDS_DEFAULT = 18;
    localparam int unsigned DIV_W_DEFAULT  = 26;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_ROT_R  = 2'd1,
        MODE_ROT_L  = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        StIdle,
        StRight,
        StLeft,
        StRot,
        StFill,
        StDrain
    } state_e;

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Control inputs and pattern outputs of the LED sequencer, bundled for the top-level port.
interface led_pattern_sequencer_if
    import led_seq_pkg::*;
#(
    parameter int unsigned N_LEDS = N_LEDS_DEFAULT,
    parameter int unsigned DIV_W  = DIV_W_DEFAULT
);
    logic [1:0]        mode;
    logic [DIV_W-1:0]  speed;
    logic              run;
    logic              step;
    logic [N_LEDS-1:0] leds;
    logic              dir;
    logic              tick;
    logic              wrap;

    modport master (
        output mode, speed, run, step,
        input  leds, dir, tick, wrap
    );

    modport slave (
        input  mode, speed, run, step,
        output leds, dir, tick, wrap
    );
endinterface

// File: rtl/led_tick_prescaler.sv
// Pattern timebase: advances every speed+1 clocks while running, or once per step while paused.
module led_tick_prescaler
    import led_seq_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] speed,
    input  logic             run,
    input  logic             step,
    output logic             adv
);
    logic [DIV_W-1:0] count_q, count_d;

    always_comb begin
        adv     = 1'b0;
        count_d = '0;
        if (run) begin
            // ">=" so a speed lowered below the running count fires immediately
            adv     = (count_q >= speed);
            count_d = adv ? '0 : count_q + DIV_W'(1);
        end else begin
            adv = step;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/led_pattern_sequencer.sv
// LED bar sequencer: bounce, rotate right/left and fill/drain patterns on a programmable timebase.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned N_LEDS = N_LEDS_DEFAULT,
    parameter int unsigned DIV_W  = DIV_W_DEFAULT
) (
    input logic                    clk,
    input logic                    rst,
    led_pattern_sequencer_if.slave bus
);
    localparam logic [N_LEDS-1:0] LedMsb = {1'b1, {(N_LEDS-1){1'b0}}};
    localparam logic [N_LEDS-1:0] LedLsb = {{(N_LEDS-1){1'b0}}, 1'b1};
    localparam logic [N_LEDS-1:0] LedAll = {N_LEDS{1'b1}};

    logic [N_LEDS-1:0] leds_q, leds_d, fill_nxt, drain_nxt, inv;
    logic              dir_q, dir_d, tick_q, tick_d, wrap_q, wrap_d;
    logic              adv, reseed, fill_ok, drain_ok;
    state_e            state_q, state_d;
    mode_e             mode_q, mode_d, mode_in;

    assign mode_in = mode_e'(bus.mode);

    led_tick_prescaler #(
        .DIV_W(DIV_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .speed(bus.speed),
        .run  (bus.run),
        .step (bus.step),
        .adv  (adv)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        leds_d    = leds_q;
        dir_d     = dir_q;
        tick_d    = 1'b0;
        wrap_d    = 1'b0;
        reseed    = 1'b0;
        fill_nxt  = {1'b1, leds_q[N_LEDS-1:1]};
        drain_nxt = {1'b0, leds_q[N_LEDS-1:1]};
        inv       = ~leds_q;
        // Legal fill values are ones packed at the MSB end, drain values ones packed at bit 0.
        fill_ok   = ((inv & (inv + LedLsb)) == '0);
        drain_ok  = ((leds_q & (leds_q + LedLsb)) == '0) && (leds_q != '0);

        if (adv) begin
            tick_d = 1'b1;
            if ((mode_in != mode_q) || (state_q == StIdle)) begin
                mode_d = mode_in;
                reseed = 1'b1;
            end else begin
                unique case (state_q)
                    StRight: begin
                        if (!$onehot(leds_q)) begin
                            reseed = 1'b1;
                        end else if (leds_q == LedLsb) begin
                            leds_d  = leds_q << 1;
                            state_d = StLeft;
                            dir_d   = 1'b1;
                        end else begin
                            leds_d = leds_q >> 1;
                        end
                    end
                    StLeft: begin
                        if (!$onehot(leds_q)) begin
                            reseed = 1'b1;
                        end else if (leds_q == LedMsb) begin
                            leds_d  = leds_q >> 1;
                            state_d = StRight;
                            dir_d   = 1'b0;
                        end else begin
                            leds_d = leds_q << 1;
                            wrap_d = (leds_q == (LedMsb >> 1));
                        end
                    end
                    StRot: begin
                        if (!$onehot(leds_q)) begin
                            reseed = 1'b1;
                        end else if (mode_q == MODE_ROT_L) begin
                            leds_d = {leds_q[N_LEDS-2:0], leds_q[N_LEDS-1]};
                            wrap_d = (leds_q == LedMsb);
                        end else begin
                            leds_d = {leds_q[0], leds_q[N_LEDS-1:1]};
                            wrap_d = (leds_q == LedLsb);
                        end
                    end
                    StFill: begin
                        if (!fill_ok) begin
                            reseed = 1'b1;
                        end else begin
                            leds_d = fill_nxt;
                            if (fill_nxt == LedAll) begin
                                state_d = StDrain;
                                dir_d   = 1'b1;
                            end
                        end
                    end
                    StDrain: begin
                        if (!drain_ok) begin
                            reseed = 1'b1;
                        end else begin
                            leds_d = drain_nxt;
                            if (drain_nxt == '0) begin
                                wrap_d  = 1'b1;
                                state_d = StFill;
                                dir_d   = 1'b0;
                            end
                        end
                    end
                    default: reseed = 1'b1;
                endcase
            end
        end

        if (reseed) begin
            wrap_d = 1'b0;
            unique case (mode_d)
                MODE_BOUNCE: begin leds_d = LedMsb; dir_d = 1'b0; state_d = StRight; end
                MODE_ROT_R:  begin leds_d = LedMsb; dir_d = 1'b0; state_d = StRot;   end
                MODE_ROT_L:  begin leds_d = LedLsb; dir_d = 1'b1; state_d = StRot;   end
                MODE_FILL:   begin leds_d = LedMsb; dir_d = 1'b0; state_d = StFill;  end
                default:     begin leds_d = LedMsb; dir_d = 1'b0; state_d = StRight; end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            mode_q  <= MODE_BOUNCE;
            leds_q  <= '0;
            dir_q   <= 1'b0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            leds_q  <= leds_d;
            dir_q   <= dir_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.leds = leds_q;
    assign bus.dir  = dir_q;
    assign bus.tick = tick_q;
    assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Self-checking bench for led_pattern_sequencer: vector table plus tick scoreboard.
module tb_led_pattern_sequencer;
    localparam int unsigned NL = 18;
    localparam int unsigned DW = 26;

    typedef struct {
        logic [1:0]    mode;
        logic [NL-1:0] leds;
        logic          dir;
        logic          chk_dir;
        logic          wrap;
    } vec_t;

    typedef struct {
        logic [NL-1:0] leds;
        logic          dir;
        logic          chk_dir;
        logic          wrap;
    } exp_t;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    vec_t vecs[$];
    exp_t exp_q[$];

    led_pattern_sequencer_if #(.N_LEDS(NL), .DIV_W(DW)) bus ();

    led_pattern_sequencer #(.N_LEDS(NL), .DIV_W(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic exp_t bounce_exp(input int t);
        exp_t e;
        e.chk_dir = 1'b1;
        if (t <= 18) begin
            e.leds = 18'(1) << (18 - t);
            e.dir  = 1'b0;
        end else begin
            e.leds = 18'(1) << (t - 18);
            e.dir  = 1'b1;
        end
        e.wrap = (t == 35);
        return e;
    endfunction

    task automatic push(input logic [NL-1:0] l, input logic d, input logic cd, input logic w);
        exp_t e;
        e.leds = l; e.dir = d; e.chk_dir = cd; e.wrap = w;
        exp_q.push_back(e);
    endtask

    task automatic wait_tick(input int budget, output int waited);
        waited = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (bus.tick) begin
                waited = i;
                break;
            end
        end
    endtask

    task automatic expect_tick(input int budget, input string name);
        int   waited;
        exp_t e;
        wait_tick(budget, waited);
        if (waited < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no tick within %0d cycles", name, budget);
            if (exp_q.size() > 0) e = exp_q.pop_front();
        end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: tick with leds=%0h but none expected", name, bus.leds);
        end else begin
            e = exp_q.pop_front();
            check({name, "_leds"}, 32'(bus.leds), 32'(e.leds));
            check({name, "_wrap"}, 32'(bus.wrap), 32'(e.wrap));
            if (e.chk_dir) check({name, "_dir"}, 32'(bus.dir), 32'(e.dir));
        end
    endtask

    task automatic expect_quiet(input int cycles, input string name);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.tick) seen++;
        end
        check(name, 32'(seen), 32'd0);
    endtask

    initial begin
        vec_t v;
        exp_t e;
        int   waited;
        logic [NL-1:0] exp_step[3];
        errors = 0;
        checks = 0;

        // Vector table: bounce, fill/drain, rotate-left then switch to rotate-right.
        for (int t = 1; t <= 35; t++) begin
            e = bounce_exp(t);
            v.mode = 2'd0; v.leds = e.leds; v.dir = e.dir; v.chk_dir = 1'b1; v.wrap = e.wrap;
            vecs.push_back(v);
        end
        for (int t = 1; t <= 37; t++) begin
            v.mode = 2'd3; v.chk_dir = 1'b1; v.wrap = (t == 36);
            if (t <= 18) begin
                v.leds = ((18'(1) << t) - 18'(1)) << (18 - t);
                v.dir  = (t == 18);
            end else if (t <= 36) begin
                v.leds = (18'(1) << (36 - t)) - 18'(1);
                v.dir  = (t != 36);
            end else begin
                v.leds = 18'h20000;
                v.dir  = 1'b0;
            end
            vecs.push_back(v);
        end
        for (int t = 0; t < 5; t++) begin
            v.mode = 2'd2; v.leds = 18'(1) << t; v.dir = 1'b0; v.chk_dir = 1'b0; v.wrap = 1'b0;
            vecs.push_back(v);
        end
        for (int k = 0; k <= 18; k++) begin
            v.mode = 2'd1; v.leds = 18'h20000 >> (k % 18); v.dir = 1'b0; v.chk_dir = 1'b0;
            v.wrap = (k == 18);
            vecs.push_back(v);
        end

        rst = 1'b1;
        bus.mode = 2'd0; bus.speed = '0; bus.run = 1'b0; bus.step = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_leds", 32'(bus.leds), 32'd0);
        check("reset_flags", {29'd0, bus.dir, bus.tick, bus.wrap}, 32'd0);
        rst = 1'b0;
        bus.run = 1'b1;

        foreach (vecs[i]) begin
            bus.mode = vecs[i].mode;
            push(vecs[i].leds, vecs[i].dir, vecs[i].chk_dir, vecs[i].wrap);
            expect_tick(3, $sformatf("vec%0d", i));
        end

        // Rate: speed=3 gives a tick every 4th clock.
        bus.speed = 26'd3;
        for (int i = 0; i < 3; i++) begin
            wait_tick(10, waited);
            check($sformatf("speed3_gap%0d", i), 32'(waited), 32'd4);
        end
        bus.speed = 26'd9;
        wait_tick(20, waited);
        check("speed9_gap", 32'(waited), 32'd10);
        expect_quiet(5, "speed9_no_tick");
        bus.speed = 26'd2;
        wait_tick(5, waited);
        check("speed_lowered_gap", 32'(waited), 32'd1);
        for (int i = 0; i < 2; i++) begin
            wait_tick(10, waited);
            check($sformatf("speed2_gap%0d", i), 32'(waited), 32'd3);
        end

        // Paused single steps in fill mode.
        bus.run = 1'b0;
        bus.mode = 2'd3;
        expect_quiet(3, "paused_no_tick");
        exp_step[0] = 18'h20000; exp_step[1] = 18'h30000; exp_step[2] = 18'h38000;
        for (int i = 0; i < 3; i++) begin
            bus.step = 1'b1;
            push(exp_step[i], 1'b0, 1'b1, 1'b0);
            expect_tick(1, $sformatf("step%0d", i));
            bus.step = 1'b0;
            expect_quiet(3, $sformatf("step%0d_gap", i));
            check($sformatf("step%0d_hold", i), 32'(bus.leds), 32'(exp_step[i]));
        end
        bus.speed = 26'd1000;
        bus.run = 1'b1;
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        expect_quiet(5, "step_ignored_running");
        check("step_ignored_leds", 32'(bus.leds), 32'h38000);

        // Bounce into the leftward leg, then reset asynchronously between edges.
        bus.speed = '0;
        bus.mode = 2'd0;
        for (int t = 1; t <= 20; t++) begin
            e = bounce_exp(t);
            exp_q.push_back(e);
            expect_tick(1003, $sformatf("pre_rst%0d", t));
        end
        #2 rst = 1'b1;
        #1;
        check("async_rst_leds", 32'(bus.leds), 32'd0);
        check("async_rst_flags", {29'd0, bus.dir, bus.tick, bus.wrap}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push(18'h20000, 1'b0, 1'b1, 1'b0);
        expect_tick(3, "post_rst_seed");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
